alarm_button_controller: RTL
============================

# alarm_button_controller

Mode controller that turns the single-cycle press pulses from the five board pushbutton detectors into the alarm clock's adjust-mode sequencing. It sits between the debounced/synchronized/edge-detected button pulses and the time/alarm counters. It arbitrates simultaneous presses and walks a set-mode state machine. It issues one-cycle increment/decrement strobes to the selected field and returns to normal display after an idle timeout.

## Interface
- TIMEOUT_S, 10, idle seconds in adjust mode before automatic return to NORMAL; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btnC_p  in  1  center press pulse, one clk wide.
- btnU_p  in  1  up press pulse.
- btnD_p  in  1  down press pulse.
- btnL_p  in  1  left press pulse.
- btnR_p  in  1  right press pulse.
- tick_1hz  in  1  one-clk-wide pulse once per second.
- adjust_mode  out  1  high in any SET state.
- field_sel  out  2  0=clock hours, 1=clock minutes, 2=alarm hours, 3=alarm minutes; valid only while adjust_mode=1.
- inc_p  out  1  one-clk increment strobe to field_sel.
- dec_p  out  1  one-clk decrement strobe to field_sel.
- alarm_en  out  1  alarm armed flag.

## Operation
- States: NORMAL, SET_CH, SET_CM, SET_AH, SET_AM. field_sel encodes SET state in that order; adjust_mode = (state != NORMAL).
- Arbitration: only one button acts per cycle, in fixed priority C > R > L > U > D. Lower-priority pulses in the same cycle are discarded, not queued.
- NORMAL:
  - C -> SET_CH.
  - U toggles alarm_en.
  - R, L, D are ignored.
  - inc_p and dec_p are never asserted in NORMAL.
- Any SET state:
  - C -> NORMAL.
  - R -> next field: CH->CM->AH->AM->CH, with wrap-around.
  - L -> previous field: CH->AM->AH->CM->CH, with wrap-around.
  - U -> inc_p for the current field; no state change.
  - D -> dec_p for the current field; no state change.
- Idle timeout:
  - Counter idle_cnt, width 8, active only in SET states.
  - Cleared on entering a SET state and on any accepted button action.
  - Increments on tick_1hz.
  - When a tick would make idle_cnt == TIMEOUT_S, the state goes to NORMAL and idle_cnt clears.
  - In NORMAL, idle_cnt is held at 0.
- Simultaneous button and tick in the same cycle: the button wins. idle_cnt clears and the tick is dropped.
- Timeout and U/D in the same cycle: the button wins (see above), so an inc_p/dec_p is issued and no timeout occurs.
- alarm_en is unaffected by SET-mode activity and by timeout.

## Timing
- All outputs are registered.
- Reset values: state=NORMAL, adjust_mode=0, field_sel=0, inc_p=0, dec_p=0, alarm_en=0, idle_cnt=0.
- Reset mid-operation aborts any SET state and drops a pending strobe on the next edge. A pulse coincident with rst is ignored.
- Latency: button pulse at cycle N -> state/field_sel/alarm_en change, or inc_p/dec_p high, visible at cycle N+1.
- inc_p and dec_p are exactly one cycle wide per accepted press and are never both high.
- Back-to-back pulses on consecutive cycles each produce one action, with no dead cycle.
- Timeout: after TIMEOUT_S ticks with no accepted press, adjust_mode falls on the cycle after the TIMEOUT_S-th tick.

## Test plan
- Reset, then C pulse -> next cycle adjust_mode=1, field_sel=0. Then U pulse -> inc_p high for exactly 1 cycle; D pulse -> dec_p high for exactly 1 cycle.
- In SET_CH: R x4 -> field_sel 1,2,3,0. L x1 -> field_sel 3. C -> adjust_mode=0; a following U toggles alarm_en 0->1 with no inc_p.
- In SET_CM, drive C, R and U in the same cycle -> NORMAL, field unchanged, no inc_p. Drive L and D together in SET_AH -> field_sel=1, dec_p=0.
- TIMEOUT_S=3: enter SET, send 2 ticks, then U -> inc_p. Then 3 more ticks -> adjust_mode drops after the 3rd tick. A tick and U in the same cycle resets the count (needs 3 fresh ticks).
- Assert rst while in SET_AM with a U pulse coincident -> all outputs return to reset values, inc_p stays 0, alarm_en=0.
- Randomized pulses for 10k cycles -> inc_p and dec_p are never both high, never asserted while adjust_mode=0, and each is at most 1 cycle wide.

Source files
------------

// File: rtl/alarm_button_controller.sv
// Adjust-mode controller for the alarm clock: arbitrates button press pulses,
// walks the set-field state machine, issues inc/dec strobes and times out to NORMAL.
module alarm_button_controller #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC_p,
    input  logic       btnU_p,
    input  logic       btnD_p,
    input  logic       btnL_p,
    input  logic       btnR_p,
    input  logic       tick_1hz,
    output logic       adjust_mode,
    output logic [1:0] field_sel,
    output logic       inc_p,
    output logic       dec_p,
    output logic       alarm_en
);

    // Bit 2 marks a SET state; bits [1:0] are the field that state adjusts.
    typedef enum logic [2:0] {
        NORMAL = 3'b000,
        SET_CH = 3'b100,
        SET_CM = 3'b101,
        SET_AH = 3'b110,
        SET_AM = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_C,
        BTN_R,
        BTN_L,
        BTN_U,
        BTN_D
    } btn_e;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_S);

    state_e     state_q, state_d;
    logic [1:0] field_q, field_d;
    logic [7:0] idle_q, idle_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       alarm_q, alarm_d;
    btn_e       btn;

    // Fixed priority C > R > L > U > D; losers in the same cycle are dropped.
    always_comb begin
        if (btnC_p)      btn = BTN_C;
        else if (btnR_p) btn = BTN_R;
        else if (btnL_p) btn = BTN_L;
        else if (btnU_p) btn = BTN_U;
        else if (btnD_p) btn = BTN_D;
        else             btn = BTN_NONE;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        alarm_d = alarm_q;

        if (state_q == NORMAL) begin
            idle_d = 8'd0;
            case (btn)
                BTN_C:   state_d = SET_CH;
                BTN_U:   alarm_d = ~alarm_q;
                default: ;
            endcase
        end else begin
            // Any accepted press restarts the idle window and swallows a same-cycle tick.
            idle_d = 8'd0;
            case (btn)
                BTN_C:   state_d = NORMAL;
                BTN_R:   state_d = state_e'({1'b1, state_q[1:0] + 2'd1});
                BTN_L:   state_d = state_e'({1'b1, state_q[1:0] - 2'd1});
                BTN_U:   inc_d   = 1'b1;
                BTN_D:   dec_d   = 1'b1;
                default: begin
                    idle_d = idle_q;
                    if (tick_1hz) begin
                        if (idle_q + 8'd1 == TIMEOUT_LIM) begin
                            state_d = NORMAL;
                            idle_d  = 8'd0;
                        end else begin
                            idle_d = idle_q + 8'd1;
                        end
                    end
                end
            endcase
        end

        // The selected field is held while in NORMAL.
        field_d = (state_d == NORMAL) ? field_q : state_d[1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            field_q <= 2'd0;
            idle_q  <= 8'd0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            idle_q  <= idle_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            alarm_q <= alarm_d;
        end
    end

    assign adjust_mode = state_q[2];
    assign field_sel   = field_q;
    assign inc_p       = inc_q;
    assign dec_p       = dec_q;
    assign alarm_en    = alarm_q;

endmodule
